chan_mux_arb: RTL and testbench
===============================

CHAN_MUX_ARB -- requirements
Module: chan_mux_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width per channel.
REQ-002 SHALL have parameter NCH, default 9: channel count, legal range 2..16.
REQ-003 SHALL have parameter SELW, default 4: select width; SELW >= clog2(NCH) SHALL be checked at elaboration.
REQ-004 SHALL have port clk, input, 1: the only clock. Reset is synchronous and active-low.
REQ-005 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-006 SHALL have port mode, input, 1: 0 = DIRECT select, 1 = ROUND_ROBIN arbitration.
REQ-007 SHALL have port sel, input, SELW: channel index used in DIRECT mode.
REQ-008 SHALL have port in_data, input, NCH*WIDTH: flattened channel data, where channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid, input, NCH: per-channel valid.
REQ-010 SHALL have port in_ready, output, NCH: per-channel accept, at most one bit set.
REQ-011 SHALL have port out_data, output, WIDTH: registered selected word.
REQ-012 SHALL have port out_valid, output, 1: out_data is held and valid.
REQ-013 SHALL have port out_ready, input, 1: the consumer accepts out_data.
REQ-014 SHALL have port out_chan, output, SELW: source channel of out_data.
REQ-015 SHALL have port sel_err, output, 1: one-cycle pulse on an out-of-range DIRECT select.

Function
REQ-016 SHALL hold a single-entry output register controlled by a two-state FSM: EMPTY and FULL.
REQ-017 SHALL define load_en = (state==EMPTY) | (out_valid & out_ready), so a word may be drained and refilled in the same cycle.
REQ-018 SHALL, in DIRECT mode, make the grant candidate sel when sel < NCH and in_valid[sel] = 1; otherwise there is no grant.
REQ-019 SHALL, in ROUND_ROBIN mode, grant the first channel with valid set, searching from rr_ptr+1 upward and wrapping modulo NCH.
REQ-020 SHALL drive in_ready[g] = 1 combinationally only when load_en = 1 and channel g is granted; all other in_ready bits SHALL be 0.
REQ-021 SHALL, on an in_valid[g] & in_ready[g] transfer, register out_data <= channel g data and out_chan <= g, set out_valid = 1 on the next cycle, and enter FULL; latency is 1 cycle.
REQ-022 SHALL hold out_data, out_chan and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL, on drain with no new grant, set out_valid = 0 and enter EMPTY.
REQ-024 SHALL update rr_ptr to g only on a ROUND_ROBIN transfer; DIRECT transfers SHALL leave rr_ptr unchanged.
REQ-025 SHALL apply a mode or sel change to the next load_en cycle only; a held word SHALL be unaffected.
REQ-026 SHALL, when load_en = 1, mode = DIRECT and sel >= NCH, pulse sel_err = 1 for one cycle, registered, with no transfer.
REQ-027 SHALL produce no transfer and leave state unchanged when in_valid is all zeros.
REQ-028 SHALL restart the ROUND_ROBIN search correctly after rr_ptr = NCH-1, wrapping to channel 0.

Reset
REQ-029 SHALL, when rst_n = 0 at a clk edge, set state = EMPTY, out_valid = 0, out_data = 0, out_chan = 0, sel_err = 0 and rr_ptr = NCH-1, so that channel 0 has first priority.
REQ-030 SHALL discard any held word on reset mid-operation, and in_ready SHALL be all zeros while rst_n = 0.

Structure
REQ-031 SHALL place the mode encoding (DIRECT = 0, ROUND_ROBIN = 1), the FSM state type and the default WIDTH, NCH and SELW in the shared package chan_mux_pkg.
REQ-032 SHALL implement the rotating-priority search in one sub-module, rr_arbiter, with ports req[NCH], ptr and grant_idx/grant_vld; it SHALL be purely combinational.

Verification
REQ-033 DIRECT: sel = 3, in_valid = 9'h008, ch3 = 16'hA5A5, out_ready = 1 -> in_ready = 9'h008 in the same cycle; out_data = 16'hA5A5, out_chan = 3, out_valid = 1 on the next cycle.
REQ-034 Backpressure: FULL with out_ready = 0 for 5 cycles while ch3 changes -> out_data stays 16'hA5A5 and in_ready = 0; when out_ready = 1 the new word loads on the same drain edge.
REQ-035 ROUND_ROBIN: in_valid = 9'h1FF held, out_ready = 1 -> out_chan sequence 0,1,...,8,0, with one word per cycle.
REQ-036 ROUND_ROBIN sparse: in_valid = 9'h104 after reset -> out_chan sequence 2, 8, 2, 8.
REQ-037 Error: DIRECT, sel = 4'hC, EMPTY -> sel_err pulses for 1 cycle, in_ready = 0, out_valid stays 0.
REQ-038 Reset mid-operation: FULL with out_ready = 0, rst_n = 0 for 1 cycle -> out_valid = 0, out_data = 0; the next ROUND_ROBIN grant is the lowest valid channel.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// Shared types and defaults for the channel mux/arbiter.
package chan_mux_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned NCH_DEF   = 9;
  localparam int unsigned SELW_DEF  = 4;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: first requester strictly after ptr, wrapping modulo NCH.
module rr_arbiter #(
  parameter int unsigned NCH  = 9,
  parameter int unsigned SELW = 4
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant_idx,
  output logic            grant_vld
);

  int unsigned cand;

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NCH) begin
        cand = cand - NCH;
      end
      // Constant-index compare keeps the request lookup a plain mux
      for (int unsigned k = 0; k < NCH; k++) begin
        if (!grant_vld && (cand == k) && req[k]) begin
          grant_idx = SELW'(k);
          grant_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/chan_mux_arb.sv
// N-channel mux with DIRECT select or round-robin arbitration into a single-entry output register.
module chan_mux_arb
  import chan_mux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned SELW  = SELW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan,
  output logic                 sel_err
);

  if (SELW < $clog2(NCH)) begin : g_selw_check
    $error("chan_mux_arb: SELW too narrow for NCH");
  end
  if ((NCH < 2) || (NCH > 16)) begin : g_nch_check
    $error("chan_mux_arb: NCH must be in 2..16");
  end

  state_e            state_q;
  state_e            state_d;
  logic [SELW-1:0]   rr_ptr_q;
  logic [SELW-1:0]   rr_idx;
  logic              rr_vld;
  logic              mode_rr;
  logic              dir_vld;
  logic              sel_oor;
  logic [SELW-1:0]   gnt_idx;
  logic              gnt_vld;
  logic [WIDTH-1:0]  gnt_data;
  logic              load_en;
  logic              xfer;

  assign mode_rr   = (mode_e'(mode) == MODE_RR);
  assign out_valid = (state_q == ST_FULL);

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .grant_idx (rr_idx),
    .grant_vld (rr_vld)
  );

  // DIRECT candidate; a select matching no channel is out of range
  always_comb begin
    dir_vld = 1'b0;
    sel_oor = 1'b1;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) begin
        sel_oor = 1'b0;
        dir_vld = in_valid[k];
      end
    end
  end

  always_comb begin
    gnt_idx  = mode_rr ? rr_idx : sel;
    gnt_vld  = mode_rr ? rr_vld : dir_vld;
    gnt_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (gnt_idx == SELW'(k)) begin
        gnt_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output slot may drain and refill on the same edge
  always_comb begin
    state_d  = state_q;
    in_ready = '0;
    load_en  = (state_q == ST_EMPTY) | (out_valid & out_ready);
    xfer     = load_en & gnt_vld & rst_n;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (xfer && (gnt_idx == SELW'(k))) begin
        in_ready[k] = 1'b1;
      end
    end
    case (state_q)
      ST_EMPTY: begin
        if (xfer) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready && !xfer) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Pointer resets to the last channel so channel 0 wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_chan <= '0;
      sel_err  <= 1'b0;
      rr_ptr_q <= SELW'(NCH - 1);
    end else begin
      sel_err <= load_en & ~mode_rr & sel_oor;
      if (xfer) begin
        out_data <= gnt_data;
        out_chan <= gnt_idx;
        if (mode_rr) begin
          rr_ptr_q <= gnt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_chan_mux_arb.sv
// Directed table-driven bench for chan_mux_arb with default parameters.
module tb_chan_mux_arb;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic [3:0]   sel;
  logic [143:0] in_data;
  logic [8:0]   in_valid;
  logic [8:0]   in_ready;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_chan;
  logic         sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  chan_mux_arb #(.WIDTH(16), .NCH(9), .SELW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        mode;
    logic [3:0]  sel;
    logic [8:0]  valid;
    logic [15:0] ch3;
    logic        ordy;
    logic [8:0]  e_rdy;
    logic        e_ov;
    logic [15:0] e_od;
    logic [3:0]  e_oc;
    logic        e_se;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic m, logic [3:0] s, logic [8:0] v, logic [15:0] c3,
                              logic o, logic [8:0] er, logic eov, logic [15:0] eod,
                              logic [3:0] eoc, logic ese);
    vec_t t;
    t.rst_n = r; t.mode = m; t.sel = s; t.valid = v; t.ch3 = c3; t.ordy = o;
    t.e_rdy = er; t.e_ov = eov; t.e_od = eod; t.e_oc = eoc; t.e_se = ese;
    vecs.push_back(t);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Channel k carries 16'hB000|k, except channel 3 which is driven explicitly
  task automatic drive(logic r, logic m, logic [3:0] s, logic [8:0] v, logic [15:0] c3, logic o);
    rst_n = r; mode = m; sel = s; in_valid = v; out_ready = o;
    for (int k = 0; k < 9; k++) begin
      in_data[k*16 +: 16] = (k == 3) ? c3 : (16'hB000 | 16'(k));
    end
  endtask

  initial begin
    int ch;
    int waited;
    drive(1'b0, 1'b0, 4'd0, 9'h000, 16'h0000, 1'b0);

    // reset, in_ready forced low while in reset
    add(0, 0, 4'd0, 9'h000, 16'h0000, 0, 9'h000, 0, 16'h0000, 4'd0, 0);
    add(0, 1, 4'd0, 9'h1FF, 16'h0000, 1, 9'h000, 0, 16'h0000, 4'd0, 0);
    // DIRECT load of channel 3
    add(1, 0, 4'd3, 9'h008, 16'hA5A5, 1, 9'h008, 1, 16'hA5A5, 4'd3, 0);
    // backpressure for 5 cycles; mode/sel changes must not touch the held word
    add(1, 0, 4'd3, 9'h008, 16'h1111, 0, 9'h000, 1, 16'hA5A5, 4'd3, 0);
    add(1, 0, 4'd3, 9'h008, 16'h2222, 0, 9'h000, 1, 16'hA5A5, 4'd3, 0);
    add(1, 1, 4'd3, 9'h1FF, 16'h3333, 0, 9'h000, 1, 16'hA5A5, 4'd3, 0);
    add(1, 0, 4'd0, 9'h008, 16'h4444, 0, 9'h000, 1, 16'hA5A5, 4'd3, 0);
    add(1, 0, 4'd3, 9'h008, 16'h5555, 0, 9'h000, 1, 16'hA5A5, 4'd3, 0);
    // drain and refill on the same edge
    add(1, 0, 4'd3, 9'h008, 16'h5A5A, 1, 9'h008, 1, 16'h5A5A, 4'd3, 0);
    // drain with nothing valid
    add(1, 0, 4'd3, 9'h000, 16'h5A5A, 1, 9'h000, 0, 16'h5A5A, 4'd3, 0);
    // out-of-range select pulses sel_err once
    add(1, 0, 4'hC, 9'h1FF, 16'h5A5A, 1, 9'h000, 0, 16'h5A5A, 4'd3, 1);
    add(1, 0, 4'd3, 9'h000, 16'h5A5A, 1, 9'h000, 0, 16'h5A5A, 4'd3, 0);
    // round robin over all channels, wrapping 8 -> 0
    for (int k = 0; k < 10; k++) begin
      ch = k % 9;
      add(1, 1, 4'd0, 9'h1FF, 16'hB003, 1, 9'(1 << ch), 1, 16'hB000 | 16'(ch), 4'(ch), 0);
    end
    // reset then sparse round robin 2,8,2,8
    add(0, 1, 4'd0, 9'h104, 16'hB003, 1, 9'h000, 0, 16'h0000, 4'd0, 0);
    add(1, 1, 4'd0, 9'h104, 16'hB003, 1, 9'h004, 1, 16'hB002, 4'd2, 0);
    add(1, 1, 4'd0, 9'h104, 16'hB003, 1, 9'h100, 1, 16'hB008, 4'd8, 0);
    add(1, 1, 4'd0, 9'h104, 16'hB003, 1, 9'h004, 1, 16'hB002, 4'd2, 0);
    add(1, 1, 4'd0, 9'h104, 16'hB003, 1, 9'h100, 1, 16'hB008, 4'd8, 0);
    // DIRECT transfer of ch2 leaves pointer at 8, so next RR grant is 2
    add(1, 0, 4'd2, 9'h104, 16'hB003, 1, 9'h004, 1, 16'hB002, 4'd2, 0);
    add(1, 1, 4'd0, 9'h104, 16'hB003, 1, 9'h004, 1, 16'hB002, 4'd2, 0);
    // DIRECT select of a non-valid channel: no grant, slot drains
    add(1, 0, 4'd5, 9'h104, 16'hB003, 1, 9'h000, 0, 16'hB002, 4'd2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].ch3, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      chk($sformatf("v%0d out_chan", i), 32'(out_chan), 32'(vecs[i].e_oc));
      chk($sformatf("v%0d sel_err", i), 32'(sel_err), 32'(vecs[i].e_se));
    end

    // Reset mid-operation: load ch5 (ptr 2 -> 5), hold it, then reset
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd0, 9'h0A0, 16'hB003, 1'b0);
    #1;
    chk("hold load in_ready", 32'(in_ready), 32'h020);
    @(posedge clk);
    #1;
    waited = 0;
    while (!out_valid && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("hold load out_valid", 32'(out_valid), 32'h1);
    chk("hold load out_chan", 32'(out_chan), 32'h5);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 4'd0, 9'h1FF, 16'h7777, 1'b0);
      #1;
      chk("hold in_ready", 32'(in_ready), 32'h000);
      @(posedge clk);
      #1;
      chk("hold out_data", 32'(out_data), 32'hB005);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd0, 9'h1FF, 16'h7777, 1'b0);
    #1;
    chk("mid reset in_ready", 32'(in_ready), 32'h000);
    @(posedge clk);
    #1;
    chk("mid reset out_valid", 32'(out_valid), 32'h0);
    chk("mid reset out_data", 32'(out_data), 32'h0);
    chk("mid reset out_chan", 32'(out_chan), 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd0, 9'h0A0, 16'h7777, 1'b1);
    #1;
    chk("post reset in_ready", 32'(in_ready), 32'h020);
    @(posedge clk);
    #1;
    chk("post reset out_valid", 32'(out_valid), 32'h1);
    chk("post reset out_chan", 32'(out_chan), 32'h5);
    chk("post reset out_data", 32'(out_data), 32'hB005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
